// File: rtl/uart_rx.sv
// UART receiver: two-flop input synchronizer, mid-bit sampling FSM with optional
// parity, and a single-entry output register with a valid/ready handshake.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 50000000 / 115200,
  parameter int unsigned BITS_N       = 8,
  parameter int unsigned PARITY_TYPE  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_in,
  input  logic              ready_in,
  output logic [BITS_N-1:0] data_rx,
  output logic              valid_out,
  output logic              parity_error,
  output logic              framing_error,
  output logic              overrun
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(BITS_N + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BITS_N - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              rx_meta;
  logic              rx_s;
  logic              rx_prev;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [BITS_N-1:0] shift_q;
  logic              parity_bad_q;

  logic fall_c;
  logic bit_end_c;
  logic data_sample_c;
  logic parity_sample_c;
  logic stop_sample_c;
  logic framing_drop_c;
  logic parity_drop_c;
  logic frame_good_c;
  logic handshake_c;
  logic expected_parity_c;

  // Synchronizer plus one extra flop for falling-edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_in;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fall_c) state_d = START_BIT;
      end
      START_BIT: begin
        if (cnt_q == HALF_LAST) state_d = rx_s ? IDLE : DATA_BITS;
      end
      DATA_BITS: begin
        if (bit_end_c && (idx_q == IDX_LAST))
          state_d = (PARITY_TYPE != 0) ? PARITY_BIT : STOP_BIT;
      end
      PARITY_BIT: begin
        if (bit_end_c) state_d = STOP_BIT;
      end
      STOP_BIT: begin
        if (bit_end_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fall_c          = rx_prev & ~rx_s;
    bit_end_c       = (cnt_q == BIT_LAST);
    data_sample_c   = 1'b0;
    parity_sample_c = 1'b0;
    stop_sample_c   = 1'b0;
    case (state_q)
      DATA_BITS:  data_sample_c   = bit_end_c;
      PARITY_BIT: parity_sample_c = bit_end_c;
      STOP_BIT:   stop_sample_c   = bit_end_c;
      default:    ;
    endcase
    // A low stop bit outranks a parity mismatch so only one error is reported
    framing_drop_c    = stop_sample_c & ~rx_s;
    parity_drop_c     = stop_sample_c & rx_s & parity_bad_q;
    frame_good_c      = stop_sample_c & rx_s & ~parity_bad_q;
    handshake_c       = valid_out & ready_in;
    expected_parity_c = (PARITY_TYPE == 1) ? ~^shift_q : ^shift_q;
  end

  // Bit timing counter restarts on each state entry and after each data sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      parity_bad_q <= 1'b0;
    end else begin
      if ((state_q == IDLE) || (state_d != state_q) || data_sample_c) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state_d != state_q) begin
        idx_q <= '0;
      end else if (data_sample_c) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      if (data_sample_c) begin
        shift_q <= {rx_s, shift_q[BITS_N-1:1]};
      end
      if (state_q == START_BIT) begin
        parity_bad_q <= 1'b0;
      end else if (parity_sample_c) begin
        parity_bad_q <= (rx_s != expected_parity_c);
      end
    end
  end

  // Output word register; a completion coinciding with a handshake refills it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_rx       <= '0;
      valid_out     <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      parity_error  <= parity_drop_c;
      framing_error <= framing_drop_c;
      overrun       <= frame_good_c & valid_out & ~ready_in;
      if (frame_good_c && (!valid_out || ready_in)) begin
        data_rx   <= shift_q;
        valid_out <= 1'b1;
      end else if (handshake_c) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx: one instance without parity, one with
// even parity, checked against a frame-level model of expected deliveries and pulses.
module tb_uart_rx;

  localparam int unsigned CPB = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic line0, line2, ready0, ready2;
  logic [7:0] d0, d2;
  logic v0, pe0, fe0, ov0;
  logic v2, pe2, fe2, ov2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int pe0_n = 0, fe0_n = 0, ov0_n = 0, hs0_n = 0, vh0_n = 0;
  int pe2_n = 0, fe2_n = 0, ov2_n = 0, hs2_n = 0;
  int v0_rise = -1;
  logic v0_last = 1'b0;
  logic [7:0] got0_q[$];
  logic [7:0] got2_q[$];
  logic [7:0] exp2_q[$];

  // Frame-level expectations for the even-parity instance
  int exp_pe2 = 0, exp_fe2 = 0, exp_ov2 = 0;
  bit exp_v2 = 1'b0;
  logic [7:0] exp_d2 = 8'h00;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB), .BITS_N(8), .PARITY_TYPE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .uart_in(line0), .ready_in(ready0),
    .data_rx(d0), .valid_out(v0), .parity_error(pe0),
    .framing_error(fe0), .overrun(ov0)
  );

  uart_rx #(.CLKS_PER_BIT(CPB), .BITS_N(8), .PARITY_TYPE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .uart_in(line2), .ready_in(ready2),
    .data_rx(d2), .valid_out(v2), .parity_error(pe2),
    .framing_error(fe2), .overrun(ov2)
  );

  // Event monitor: pulse counts and the words actually handed over
  always @(posedge clk) begin
    cyc++;
    if (pe0) pe0_n++;
    if (fe0) fe0_n++;
    if (ov0) ov0_n++;
    if (v0) vh0_n++;
    if (pe2) pe2_n++;
    if (fe2) fe2_n++;
    if (ov2) ov2_n++;
    if (v0 && ready0) begin hs0_n++; got0_q.push_back(d0); end
    if (v2 && ready2) begin hs2_n++; got2_q.push_back(d2); end
    if (v0 && !v0_last) v0_rise = cyc;
    v0_last = v0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input int sel, input logic b);
    if (sel == 0) line0 = b; else line2 = b;
    wait_cyc(CPB);
  endtask

  task automatic send(input int sel, input logic [7:0] d, input bit par_en,
                      input bit flip, input bit stop_hi);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (par_en) drive_bit(sel, (^d) ^ flip);
    drive_bit(sel, stop_hi);
  endtask

  task automatic set_ready2(input bit r);
    if (r && exp_v2) begin
      exp2_q.push_back(exp_d2);
      exp_v2 = 1'b0;
    end
    ready2 = r;
    wait_cyc(2);
  endtask

  task automatic frame2(input logic [7:0] d, input bit flip, input bit stop_hi, input string tag);
    send(2, d, 1'b1, flip, stop_hi);
    if (!stop_hi)       exp_fe2++;
    else if (flip)      exp_pe2++;
    else if (ready2)    exp2_q.push_back(d);
    else if (exp_v2)    exp_ov2++;
    else begin
      exp_v2 = 1'b1;
      exp_d2 = d;
    end
    line2 = 1'b1;
    wait_cyc(4);
    check({tag, "_perr"}, pe2_n, exp_pe2);
    check({tag, "_ferr"}, fe2_n, exp_fe2);
    check({tag, "_ovr"}, ov2_n, exp_ov2);
    check({tag, "_valid"}, {31'd0, v2}, {31'd0, exp_v2});
    check({tag, "_delivered"}, hs2_n, 32'(exp2_q.size()));
    if (exp_v2) check({tag, "_data"}, {24'd0, d2}, {24'd0, exp_d2});
  endtask

  int c0, hs_b, ov_b, fe_b, pe_b, vh_b, ov_d;
  logic [7:0] a, b, rd;
  bit flip, stop_hi;

  initial begin
    rst_n = 1'b0; line0 = 1'b1; line2 = 1'b1; ready0 = 1'b1; ready2 = 1'b0;
    wait_cyc(4);
    check("rst_d0", {24'd0, d0}, 0);
    check("rst_v0", {31'd0, v0}, 0);
    check("rst_pe0", {31'd0, pe0}, 0);
    check("rst_fe0", {31'd0, fe0}, 0);
    check("rst_ov0", {31'd0, ov0}, 0);
    check("rst_d2", {24'd0, d2}, 0);
    check("rst_v2", {31'd0, v2}, 0);
    check("rst_pe2", {31'd0, pe2}, 0);
    check("rst_fe2", {31'd0, fe2}, 0);
    check("rst_ov2", {31'd0, ov2}, 0);
    rst_n = 1'b1;
    wait_cyc(4);

    // Plain 0xA5 with consumer always ready: single valid cycle, ~10 bit times
    hs_b = hs0_n; vh_b = vh0_n; v0_rise = -1; c0 = cyc;
    send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    wait_cyc(8);
    check("a5_handshakes", hs0_n - hs_b, 1);
    check("a5_data", {24'd0, got0_q[$]}, 32'h A5);
    check("a5_valid_cycles", vh0_n - vh_b, 1);
    check("a5_latency_ok", {31'd0, ((v0_rise - c0) >= 9 * CPB) && ((v0_rise - c0) <= 11 * CPB)}, 1);

    // Back-to-back 0x11, 0x22 with consumer stalled: keep first, flag overrun
    ready0 = 1'b0; ov_b = ov0_n; hs_b = hs0_n;
    send(0, 8'h11, 1'b0, 1'b0, 1'b1);
    send(0, 8'h22, 1'b0, 1'b0, 1'b1);
    wait_cyc(4);
    check("ovr_data", {24'd0, d0}, 32'h11);
    check("ovr_valid", {31'd0, v0}, 1);
    check("ovr_pulses", ov0_n - ov_b, 1);
    ready0 = 1'b1;
    wait_cyc(3);
    check("ovr_drain_hs", hs0_n - hs_b, 1);
    check("ovr_drain_word", {24'd0, got0_q[$]}, 32'h11);
    check("ovr_drain_valid", {31'd0, v0}, 0);

    // Low stop bit, line then held low: one framing pulse and no retrigger
    fe_b = fe0_n; hs_b = hs0_n; ov_b = ov0_n;
    send(0, 8'h55, 1'b0, 1'b0, 1'b0);
    wait_cyc(12 * CPB);
    check("frm_pulses", fe0_n - fe_b, 1);
    check("frm_no_delivery", hs0_n - hs_b, 0);
    check("frm_valid", {31'd0, v0}, 0);
    check("frm_no_ovr", ov0_n - ov_b, 0);
    line0 = 1'b1;
    wait_cyc(2 * CPB);

    // Sweep a one-cycle ready pulse across the second frame's completion
    for (int off = 146; off <= 164; off++) begin
      ready0 = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      send(0, a, 1'b0, 1'b0, 1'b1);
      wait_cyc(4);
      hs_b = hs0_n; ov_b = ov0_n;
      fork
        send(0, b, 1'b0, 1'b0, 1'b1);
        begin
          wait_cyc(off);
          ready0 = 1'b1;
          wait_cyc(1);
          ready0 = 1'b0;
        end
      join
      wait_cyc(4);
      ov_d = ov0_n - ov_b;
      ready0 = 1'b1;
      wait_cyc(3);
      check("sweep_accounting", (hs0_n - hs_b) + ov_d, 2);
      check("sweep_last_word", {24'd0, got0_q[$]}, {24'd0, (ov_d != 0) ? a : b});
    end
    ready0 = 1'b1;

    // Even parity: good 0x3C delivered, flipped parity dropped with a pulse
    set_ready2(1'b1);
    frame2(8'h3C, 1'b0, 1'b1, "par_good");
    frame2(8'h3C, 1'b1, 1'b1, "par_flip");

    // Random frames, errors and consumer stalls against the frame model
    for (int i = 0; i < 40; i++) begin
      rd = 8'($urandom);
      flip = ($urandom_range(0, 4) == 0);
      stop_hi = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 2) == 0) set_ready2(!ready2);
      frame2(rd, flip, stop_hi, "rnd");
      wait_cyc($urandom_range(0, 12));
    end

    // Short low glitch must be rejected silently; a real frame still works
    hs_b = hs0_n; fe_b = fe0_n; pe_b = pe0_n; ov_b = ov0_n;
    line0 = 1'b0;
    wait_cyc(4);
    line0 = 1'b1;
    wait_cyc(3 * CPB);
    check("glitch_no_delivery", hs0_n - hs_b, 0);
    check("glitch_no_errors", (fe0_n - fe_b) + (pe0_n - pe_b) + (ov0_n - ov_b), 0);
    check("glitch_valid", {31'd0, v0}, 0);
    send(0, 8'h3A, 1'b0, 1'b0, 1'b1);
    wait_cyc(4);
    check("post_glitch_word", {24'd0, got0_q[$]}, 32'h3A);

    // Reset in the middle of a frame while a word is held
    set_ready2(1'b0);
    frame2(8'h77, 1'b0, 1'b1, "pre_rst");
    drive_bit(2, 1'b0);
    drive_bit(2, 1'b1);
    drive_bit(2, 1'b0);
    drive_bit(2, 1'b1);
    rst_n = 1'b0;
    line2 = 1'b1;
    wait_cyc(1);
    check("mid_rst_d2", {24'd0, d2}, 0);
    check("mid_rst_v2", {31'd0, v2}, 0);
    check("mid_rst_err2", {29'd0, pe2, fe2, ov2}, 0);
    check("mid_rst_v0", {31'd0, v0}, 0);
    rst_n = 1'b1;
    exp_v2 = 1'b0;
    wait_cyc(12 * CPB);
    check("post_rst_perr", pe2_n, exp_pe2);
    check("post_rst_ferr", fe2_n, exp_fe2);
    check("post_rst_valid", {31'd0, v2}, 0);
    set_ready2(1'b1);
    frame2(8'hF0, 1'b0, 1'b1, "after_rst");

    check("delivered_count", 32'(got2_q.size()), 32'(exp2_q.size()));
    for (int i = 0; i < exp2_q.size() && i < got2_q.size(); i++)
      check("delivered_word", {24'd0, got2_q[i]}, {24'd0, exp2_q[i]});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
